// File: rtl/multdiv_issue_ctrl.sv
// Issue controller for the sequential mult32/div32 units: latches the operands,
// pulses the unit's start input, stalls the pipeline while it iterates, then writes back.
module multdiv_issue_ctrl #(
  parameter int TIMEOUT       = 40,
  parameter int CNT_W         = 6,
  parameter int MULT_EXC_CODE = 4,
  parameter int DIV_EXC_CODE  = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x_valid,
  input  logic        x_is_mult,
  input  logic        x_is_div,
  input  logic        x_flush,
  input  logic [31:0] x_operandA,
  input  logic [31:0] x_operandB,
  input  logic [4:0]  x_rd,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] data_result,
  input  logic        data_exception,
  input  logic        data_resultRDY,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  localparam int DATA_W = 32;
  localparam logic [4:0] EXC_RD = 5'd30;
  // The counter has reached TIMEOUT-1 once the cycle that sees LAST_CNT ends.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 2);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [DATA_W-1:0] opa_q;
  logic signed [DATA_W-1:0] opb_q;
  logic signed [DATA_W-1:0] res_q;
  logic [4:0]              rd_q;
  logic                    is_div_q;
  logic                    exc_q;
  logic                    accept;
  logic                    timeout_hit;

  function automatic logic [DATA_W-1:0] exc_code(input logic is_div);
    exc_code = is_div ? DATA_W'(DIV_EXC_CODE) : DATA_W'(MULT_EXC_CODE);
  endfunction

  assign accept      = (state == IDLE) & x_valid & (x_is_mult ^ x_is_div) & ~x_flush;
  assign timeout_hit = (state == WAIT) & ~data_resultRDY & (cnt == LAST_CNT);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = x_flush ? IDLE : WAIT;
      WAIT: begin
        if (x_flush)                             state_nxt = IDLE;
        else if (data_resultRDY || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/result latches; a timeout is folded into exc_q so DONE has one exception path.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      is_div_q <= 1'b0;
      exc_q    <= 1'b0;
    end else begin
      if (accept) begin
        opa_q    <= x_operandA;
        opb_q    <= x_operandB;
        rd_q     <= x_rd;
        is_div_q <= x_is_div;
        res_q    <= '0;
        exc_q    <= 1'b0;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT && !x_flush) begin
        if (data_resultRDY) begin
          res_q <= data_result;
          exc_q <= data_exception;
        end else begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) exc_q <= 1'b1;
        end
      end
    end
  end

  assign data_operandA = opa_q;
  assign data_operandB = opb_q;

  always_comb begin
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    stall     = accept;
    busy      = (state != IDLE);
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    case (state)
      ISSUE: begin
        ctrl_MULT = ~is_div_q;
        ctrl_DIV  = is_div_q;
        stall     = 1'b1;
      end
      WAIT:  stall = 1'b1;
      DONE: begin
        if (exc_q) begin
          wb_valid = 1'b1;
          wb_rd    = EXC_RD;
          wb_data  = exc_code(is_div_q);
        end else begin
          wb_valid = (rd_q != 5'd0);
          wb_rd    = rd_q;
          wb_data  = res_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
// Directed bench for multdiv_issue_ctrl with a scripted mult/div unit response.
module tb_multdiv_issue_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        x_valid, x_is_mult, x_is_div, x_flush;
  logic [31:0] x_operandA, x_operandB;
  logic [4:0]  x_rd;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic        stall, busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // Observations collected by run_op
  int mult_pulses, div_pulses, stall_n, wb_n, done_cyc, idle_cyc;
  logic [4:0]  wb_rd_s;
  logic [31:0] wb_data_s;

  always #5 clock = ~clock;

  multdiv_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .x_valid(x_valid), .x_is_mult(x_is_mult), .x_is_div(x_is_div), .x_flush(x_flush),
    .x_operandA(x_operandA), .x_operandB(x_operandB), .x_rd(x_rd),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception), .data_resultRDY(data_resultRDY),
    .stall(stall), .busy(busy),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // cyc 0 is the offer cycle, cyc 1 the pulse cycle; rdy_at/flush_at are cyc indices (0 = never).
  task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int rdy_at, input logic [31:0] res,
                        input logic exc, input int flush_at, input int ncyc);
    mult_pulses = 0; div_pulses = 0; stall_n = 0; wb_n = 0;
    done_cyc = -1; idle_cyc = -1; wb_rd_s = '0; wb_data_s = '0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      x_valid        = (cyc == 0);
      x_is_mult      = (cyc == 0) ? m : 1'b0;
      x_is_div       = (cyc == 0) ? d : 1'b0;
      x_operandA     = a;
      x_operandB     = b;
      x_rd           = rd;
      x_flush        = (flush_at != 0) && (cyc == flush_at);
      data_resultRDY = (rdy_at != 0) && (cyc == rdy_at);
      data_result    = data_resultRDY ? res : 32'hdead_beef;
      data_exception = data_resultRDY ? exc : 1'b0;
      #1;
      if (ctrl_MULT) mult_pulses++;
      if (ctrl_DIV)  div_pulses++;
      if (stall)     stall_n++;
      if (wb_valid) begin
        wb_n++;
        wb_rd_s   = wb_rd;
        wb_data_s = wb_data;
        done_cyc  = cyc;
      end
      if (cyc > 0 && !busy && idle_cyc < 0) idle_cyc = cyc;
      tick();
    end
    x_valid = 0; x_is_mult = 0; x_is_div = 0; x_flush = 0; data_resultRDY = 0;
  endtask

  initial begin
    reset = 1; x_valid = 0; x_is_mult = 0; x_is_div = 0; x_flush = 0;
    x_operandA = 0; x_operandB = 0; x_rd = 0;
    data_result = 0; data_exception = 0; data_resultRDY = 0;
    tick(); tick();
    chk("rst_ctrl_mult", 32'(ctrl_MULT), 0);
    chk("rst_ctrl_div", 32'(ctrl_DIV), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_wb_rd", 32'(wb_rd), 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_opA", data_operandA, 0);
    chk("rst_opB", data_operandB, 0);
    reset = 0;
    tick();

    // MULT 7*6 -> r3, RDY 17 cycles after the pulse
    run_op(1, 0, 7, 6, 3, 18, 42, 0, 0, 22);
    chk("mul_pulses", mult_pulses, 1);
    chk("mul_div_pulses", div_pulses, 0);
    chk("mul_stall_cycles", stall_n, 19);
    chk("mul_wb_count", wb_n, 1);
    chk("mul_wb_rd", 32'(wb_rd_s), 3);
    chk("mul_wb_data", wb_data_s, 42);
    chk("mul_done_cyc", done_cyc, 19);
    chk("mul_idle_cyc", idle_cyc, 20);
    chk("mul_opA_held", data_operandA, 7);
    chk("mul_opB_held", data_operandB, 6);

    // DIV 10/0 -> exception, code 5 to r30, minimum latency
    run_op(0, 1, 10, 0, 5, 2, 0, 1, 0, 6);
    chk("div_pulses", div_pulses, 1);
    chk("div_mult_pulses", mult_pulses, 0);
    chk("div_wb_count", wb_n, 1);
    chk("div_wb_rd", 32'(wb_rd_s), 30);
    chk("div_wb_data", wb_data_s, 5);
    chk("div_done_cyc", done_cyc, 3);

    // MULT timeout: DONE 40 cycles after ISSUE
    run_op(1, 0, 32'h7fff_ffff, 2, 9, 0, 0, 0, 0, 46);
    chk("to_pulses", mult_pulses, 1);
    chk("to_wb_count", wb_n, 1);
    chk("to_done_cyc", done_cyc, 41);
    chk("to_wb_rd", 32'(wb_rd_s), 30);
    chk("to_wb_data", wb_data_s, 4);
    chk("to_idle_cyc", idle_cyc, 42);
    chk("to_stall_cycles", stall_n, 41);

    // Flush in the 3rd WAIT cycle, late RDY two cycles after
    run_op(1, 0, 11, 12, 4, 6, 132, 0, 4, 10);
    chk("fl_pulses", mult_pulses, 1);
    chk("fl_wb_count", wb_n, 0);
    chk("fl_stall_cycles", stall_n, 5);
    chk("fl_idle_cyc", idle_cyc, 5);

    // Both op flags set: not accepted
    run_op(1, 1, 1, 1, 6, 3, 1, 0, 0, 8);
    chk("both_mult_pulses", mult_pulses, 0);
    chk("both_div_pulses", div_pulses, 0);
    chk("both_stall", stall_n, 0);
    chk("both_wb", wb_n, 0);

    // MULT to r0: issued, no writeback
    run_op(1, 0, 9, 11, 0, 3, 99, 0, 0, 8);
    chk("r0_pulses", mult_pulses, 1);
    chk("r0_wb", wb_n, 0);
    chk("r0_idle_cyc", idle_cyc, 5);

    // Reset during WAIT
    x_valid = 1; x_is_mult = 1; x_operandA = 13; x_operandB = 14; x_rd = 2;
    tick();
    x_valid = 0; x_is_mult = 0;
    tick(); tick();
    #1;
    chk("rw_in_wait_stall", 32'(stall), 1);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rw_busy", 32'(busy), 0);
    chk("rw_stall", 32'(stall), 0);
    chk("rw_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 0);
    chk("rw_wb_valid", 32'(wb_valid), 0);
    chk("rw_opA", data_operandA, 0);
    data_resultRDY = 1; data_result = 182;
    tick();
    data_resultRDY = 0;
    #1;
    chk("rw_late_rdy_busy", 32'(busy), 0);
    chk("rw_late_rdy_wb", 32'(wb_valid), 0);

    // Back-to-back: MULT then DIV with x_valid held high
    x_valid = 1; x_is_mult = 1; x_is_div = 0; x_operandA = 3; x_operandB = 5; x_rd = 7;
    #1;
    chk("bb_accept_stall", 32'(stall), 1);
    tick();
    x_is_mult = 0; x_is_div = 1; x_operandA = 20; x_operandB = 4; x_rd = 8;
    #1;
    chk("bb_mult_pulse", 32'(ctrl_MULT), 1);
    chk("bb_mult_opA", data_operandA, 3);
    tick();
    data_resultRDY = 1; data_result = 15;
    tick();
    data_resultRDY = 0;
    #1;
    chk("bb_done_stall", 32'(stall), 0);
    chk("bb_done_wb_valid", 32'(wb_valid), 1);
    chk("bb_done_wb_rd", 32'(wb_rd), 7);
    chk("bb_done_wb_data", wb_data, 15);
    tick();
    #1;
    chk("bb_idle_busy", 32'(busy), 0);
    chk("bb_idle_accept", 32'(stall), 1);
    tick();
    x_valid = 0; x_is_div = 0;
    #1;
    chk("bb_div_pulse", 32'(ctrl_DIV), 1);
    chk("bb_div_no_mult", 32'(ctrl_MULT), 0);
    chk("bb_div_opA", data_operandA, 20);
    tick();
    data_resultRDY = 1; data_result = 5;
    tick();
    data_resultRDY = 0;
    #1;
    chk("bb_div_wb_rd", 32'(wb_rd), 8);
    chk("bb_div_wb_data", wb_data, 5);
    tick();
    #1;
    chk("bb_end_busy", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multdiv_issue_ctrl.md
Name: multdiv_issue_ctrl

Overview:
Pipeline-side initiator for the sequential mult32/div32 units. It accepts a MULT/DIV from the execute stage, latches operands and destination, and issues a one-cycle ctrl_MULT/ctrl_DIV pulse. While the unit iterates it stalls the pipeline, then captures data_result/data_exception on data_resultRDY and produces a single-cycle regfile writeback. On an exception it writes the exception code to r30 instead of writing rd.

Parameters:
TIMEOUT, 40, max cycles to wait for data_resultRDY after the ctrl pulse before forcing an exception
CNT_W, 6, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT
MULT_EXC_CODE, 4, value written to r30 on a multiply exception or timeout
DIV_EXC_CODE, 5, value written to r30 on a divide exception or timeout

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high
x_valid  in  1  execute-stage instruction valid
x_is_mult  in  1  instruction is MULT
x_is_div  in  1  instruction is DIV
x_flush  in  1  squash any in-flight or offered op
x_operandA  in  32  first operand
x_operandB  in  32  second operand
x_rd  in  5  destination register
ctrl_MULT  out  1  one-cycle start pulse to multiplier
ctrl_DIV  out  1  one-cycle start pulse to divider
data_operandA  out  32  latched operand A, held stable from pulse until DONE
data_operandB  out  32  latched operand B, same
data_result  in  32  unit result
data_exception  in  1  unit exception (overflow / divide-by-zero)
data_resultRDY  in  1  unit result valid, single-cycle
stall  out  1  freeze fetch/decode/execute
busy  out  1  high whenever state is not IDLE
wb_valid  out  1  regfile write enable, single cycle
wb_rd  out  5  write address
wb_data  out  32  write data

Behaviour:
- States: IDLE, ISSUE, WAIT, DONE. On reset, state=IDLE, counter=0, and all outputs and latches are 0.
- accept = IDLE & x_valid & (x_is_mult XOR x_is_div) & ~x_flush. Both flags high, or neither, means no accept.
- stall = accept | (state is ISSUE or WAIT). stall is combinational and low in IDLE without accept, and low in DONE.
- IDLE -> ISSUE on accept. At that edge, latch operandA, operandB, rd, and op type.
- ISSUE lasts exactly 1 cycle. The matching ctrl_* is high only in this cycle. Counter clears to 0. Next state is WAIT.
- WAIT:
  - data_resultRDY=1: capture data_result and data_exception, then go to DONE.
  - Otherwise the counter increments. If counter reaches TIMEOUT-1 without RDY, go to DONE with forced exception.
  - Any data_resultRDY during ISSUE is ignored.
- DONE lasts 1 cycle, then returns to IDLE. No accept is possible in DONE, so the same instruction cannot be re-issued as the pipeline advances.
- DONE outputs:
  - Exception or timeout: wb_valid=1, wb_rd=30, wb_data = MULT_EXC_CODE or DIV_EXC_CODE (zero-extended).
  - Otherwise wb_rd = latched rd and wb_data = captured result. wb_valid=1 unless rd==0, in which case wb_valid=0.
- wb_valid is 0 in all other states. wb_rd and wb_data are 0 outside DONE.
- x_flush in ISSUE or WAIT: next state IDLE, no writeback. A late RDY arriving in IDLE is ignored. x_flush in DONE has no effect, since writeback is committed.
- reset mid-operation (any state): IDLE next cycle, no pulse, no writeback.
- Minimum latency from the accept edge to wb_valid is 3 cycles (RDY one cycle after the pulse).

Test Plan:
- MULT A=7, B=6, rd=3; unit RDY 17 cycles after pulse with result 42, exc=0 -> exactly one ctrl_MULT pulse; stall high for 1+1+17 cycles; wb_valid=1, wb_rd=3, wb_data=42 for one cycle; stall low in DONE.
- DIV A=10, B=0, rd=5; RDY with exc=1 -> wb_rd=30, wb_data=5, no write to r5.
- MULT with RDY never asserted, TIMEOUT=40 -> DONE 40 cycles after ISSUE; wb_rd=30, wb_data=4; busy falls the next cycle.
- x_flush in the 3rd WAIT cycle, RDY two cycles later -> state IDLE, wb_valid never asserted, stall low after flush.
- x_valid with x_is_mult=x_is_div=1, and separately MULT with rd=0 and result 99 -> no pulse for the first case; for the second, pulse issued but wb_valid=0 in DONE.
- reset asserted during WAIT, then back-to-back MULT/DIV -> all outputs 0 after reset; second op accepted only in the IDLE cycle after the first op's DONE.
